ft600_mode245: RTL and testbench
================================

Name: ft600_mode245

Overview:
- Bridge between on-chip user logic and an FTDI FT600 USB 3.0 FIFO chip in 245 synchronous FIFO mode.
- Holds one TX FIFO (user → USB) and one RX FIFO (USB → user) of 16-bit words.
- A bus state machine moves words between the FIFOs and the FT600 half-duplex bus.
- The whole block runs on the FT600 CLK output (66/100 MHz), so user logic attached here must run on that clock too.

Parameters:
- RX_BUF_WIDTH, 8, log2 of RX FIFO depth in 16-bit words (default 256 words).
- TX_BUF_WIDTH, 8, log2 of TX FIFO depth in 16-bit words (default 256 words).

Ports:
- clk  in  1  single block clock, driven by the FT600 CLK pin; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tx_en  in  1  push tx_in into TX FIFO this cycle.
- tx_in  in  16  word to send to host.
- tx_full  out  1  TX FIFO full.
- rx_en  in  1  pop one word from RX FIFO this cycle.
- rx_out  out  16  registered popped word.
- rx_empty  out  1  RX FIFO empty.
- ft_data  inout  16  FT600 DATA bus.
- ft_be  inout  2  FT600 byte enables.
- ft_txe  in  1  active low; FT600 can accept a write.
- ft_rxf  in  1  active low; FT600 has read data.
- ft_oe  out  1  active-low output enable to FT600.
- ft_rd  out  1  active-low read strobe.
- ft_wr  out  1  active-low write strobe.

Behaviour:
Reset (async, rst_n low):
- Both FIFOs empty; state IDLE.
- ft_oe, ft_rd, ft_wr = 1; ft_data and ft_be released (Z).
- rx_out = 0; tx_full = 0; rx_empty = 1.
- Reset mid-transfer aborts immediately. No partial-word recovery.

User side:
- A push occurs when tx_en=1 and tx_full=0 at the clock edge. A push while full is dropped, even if the FIFO pops in the same cycle.
- A pop occurs when rx_en=1 and rx_empty=0. rx_out takes the head word on that edge (1-cycle latency) and holds it otherwise. rx_en while empty is ignored and rx_out is unchanged.
- tx_full and rx_empty reflect occupancy after the edge. Pointers wrap modulo 2^WIDTH. Occupancy counter is WIDTH+1 bits.

Bus ownership:
- FPGA drives ft_data/ft_be only in state TX. In TX, ft_be = 2'b11 and ft_data = TX FIFO head (first-word-fall-through).
- Released in all other states.

FSM states: IDLE, RX_OE, RX_READ, RX_END, TX.
- IDLE, RX start: if ft_rxf=0 and RX free slots ≥ 4 → RX_OE. RX has priority.
- IDLE, TX start: else if ft_txe=0 and TX FIFO non-empty → TX.
- RX_OE: ft_oe=0, ft_rd=1 for exactly one cycle (bus turnaround) → RX_READ.
- RX_READ: ft_oe=0, ft_rd=0.
  - Each edge with ft_rxf=0 writes ft_data into the RX FIFO. ft_be is ignored; words are always 16 bit.
  - Leave to RX_END when ft_rxf=1 (no write that edge) or when free slots drop to ≤ 2 after the write.
- RX_END: ft_oe=1, ft_rd=1 for one cycle → IDLE.
- TX: ft_wr = 0 while TX FIFO non-empty.
  - A word is transferred (popped) on each edge with ft_wr=0 and ft_txe=0.
  - ft_txe=1 stalls: word held, not popped, and state → IDLE.
  - FIFO becoming empty after a pop → IDLE.
- Minimum one IDLE cycle between any two bursts, which guarantees bus turnaround.
- Simultaneous user push during TX pop, or user pop during RX write, is legal. Occupancy changes by the net amount.

Decomposition:
- Package ft600_pkg: state enum, DATA_W=16, BE_W=2, RX_MARGIN=2, RX_START_FREE=4.
- One sub-module ft600_sync_fifo (params WIDTH, DATA_W; FWFT head output, count output), instantiated twice.
- FSM and tristate control live in the top.

Test Plan:
- Reset then idle with ft_txe=ft_rxf=1 → ft_oe/ft_rd/ft_wr=1, ft_data=Z, rx_empty=1, tx_full=0, rx_out=0.
- Push 0x0001,0x0203,0x0405; hold ft_txe=0 → TX entered, ft_wr low exactly 3 cycles, ft_data sequence 0x0001,0x0203,0x0405, ft_be=11, then IDLE.
- Same TX burst with ft_txe=1 for one cycle after first word → 0x0203 not lost, resent after ft_txe returns low; host model receives all three in order.
- Host model holds ft_rxf=0 with words 0xFEDC,0xBA98 then raises ft_rxf → ft_oe low one cycle before ft_rd. After rx_en pulses, rx_out = 0xFEDC then 0xBA98, and rx_empty returns to 1.
- RX_BUF_WIDTH=3 with 20 host words pending → reading stops at ≥ 6 stored, ft_rd deasserts, no overflow. After the user drains, reading resumes and all 20 words arrive in order.
- 257 pushes with no host (ft_txe=1) → tx_full after 256, 257th dropped. rst_n pulse mid-RX_READ → all strobes high same cycle, FIFOs empty.

Source files
------------

// File: rtl/ft600_pkg.sv
// Shared types and constants for the FT600 245-mode synchronous FIFO bridge.
package ft600_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned BE_W          = 2;
  localparam int unsigned RX_MARGIN     = 2;
  localparam int unsigned RX_START_FREE = 4;

  typedef enum logic [2:0] {
    IDLE,
    RX_OE,
    RX_READ,
    RX_END,
    TX
  } ft_state_e;

endpackage

// File: rtl/ft600_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
module ft600_sync_fifo #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] head,
  output logic [WIDTH:0]    count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned DEPTH = 1 << WIDTH;
  localparam logic [WIDTH:0] FULL_CNT = {1'b1, {WIDTH{1'b0}}};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [WIDTH:0]    count_q, count_d;
  logic              push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign push = wr_en && !full;
  assign pop  = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ft600_mode245.sv
// FT600 245 synchronous FIFO bridge: TX/RX word FIFOs plus the half-duplex bus FSM.
module ft600_mode245
  import ft600_pkg::*;
#(
  parameter int unsigned RX_BUF_WIDTH = 8,
  parameter int unsigned TX_BUF_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_en,
  input  logic [DATA_W-1:0] tx_in,
  output logic              tx_full,
  input  logic              rx_en,
  output logic [DATA_W-1:0] rx_out,
  output logic              rx_empty,
  inout  wire  [DATA_W-1:0] ft_data,
  inout  wire  [BE_W-1:0]   ft_be,
  input  logic              ft_txe,
  input  logic              ft_rxf,
  output logic              ft_oe,
  output logic              ft_rd,
  output logic              ft_wr
);

  localparam int unsigned RW = RX_BUF_WIDTH + 1;
  localparam int unsigned TW = TX_BUF_WIDTH + 1;
  localparam logic [RX_BUF_WIDTH:0] RX_DEPTH = {1'b1, {RX_BUF_WIDTH{1'b0}}};

  ft_state_e state_q, state_d;

  logic [DATA_W-1:0]       rx_out_q, rx_out_d;
  logic [DATA_W-1:0]       tx_head, rx_head;
  logic [TX_BUF_WIDTH:0]   tx_count;
  logic [RX_BUF_WIDTH:0]   rx_count;
  logic [RX_BUF_WIDTH:0]   rx_free, rx_free_next;
  logic                    tx_empty, rx_full;
  logic                    tx_push, tx_pop, rx_push, rx_pop;
  logic                    tx_last_pop;
  logic                    bus_drive;

  assign tx_push = tx_en && !tx_full;
  assign rx_pop  = rx_en && !rx_empty;
  assign tx_pop  = (state_q == TX) && !tx_empty && !ft_txe;
  assign rx_push = (state_q == RX_READ) && !ft_rxf && !rx_full;

  assign rx_free      = RX_DEPTH - rx_count;
  assign rx_free_next = rx_free - RW'(rx_push) + RW'(rx_pop);
  assign tx_last_pop  = tx_pop && !tx_push && (tx_count == TW'(1));

  ft600_sync_fifo #(
    .WIDTH  (TX_BUF_WIDTH),
    .DATA_W (DATA_W)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_en),
    .wr_data (tx_in),
    .rd_en   (tx_pop),
    .head    (tx_head),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  ft600_sync_fifo #(
    .WIDTH  (RX_BUF_WIDTH),
    .DATA_W (DATA_W)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rx_push),
    .wr_data (ft_data),
    .rd_en   (rx_en),
    .head    (rx_head),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_comb begin
    state_d   = state_q;
    ft_oe     = 1'b1;
    ft_rd     = 1'b1;
    ft_wr     = 1'b1;
    bus_drive = 1'b0;
    case (state_q)
      IDLE: begin
        if (!ft_rxf && (rx_free >= RW'(RX_START_FREE))) state_d = RX_OE;
        else if (!ft_txe && !tx_empty)                  state_d = TX;
      end
      RX_OE: begin
        ft_oe   = 1'b0;
        state_d = RX_READ;
      end
      RX_READ: begin
        ft_oe = 1'b0;
        ft_rd = 1'b0;
        // Stop with a margin of free slots so words still in flight cannot overflow.
        if (ft_rxf || (rx_free_next <= RW'(RX_MARGIN))) state_d = RX_END;
      end
      RX_END: begin
        state_d = IDLE;
      end
      TX: begin
        bus_drive = 1'b1;
        ft_wr     = tx_empty;
        if (ft_txe || tx_empty || tx_last_pop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_out_d = rx_out_q;
    if (rx_pop) rx_out_d = rx_head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rx_out_q <= '0;
    end else begin
      state_q  <= state_d;
      rx_out_q <= rx_out_d;
    end
  end

  assign rx_out  = rx_out_q;
  assign ft_data = bus_drive ? tx_head : 'z;
  assign ft_be   = bus_drive ? 2'b11 : 'z;

endmodule

// File: tb/tb_ft600_mode245.sv
// Directed self-checking bench for ft600_mode245 with a simple FT600 host model.
module tb_ft600_mode245;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic [15:0] tx_in = '0;
  logic        tx_full;
  logic        rx_en = 1'b0;
  logic [15:0] rx_out;
  logic        rx_empty;
  wire  [15:0] ft_data;
  wire  [1:0]  ft_be;
  logic        ft_txe = 1'b1;
  logic        ft_rxf;
  logic        ft_oe, ft_rd, ft_wr;

  int n_pass = 0;
  int n_checks = 0;

  // Host model: RX source words, TX sink words, write-strobe cycle count.
  logic [15:0] host_src [64];
  int          host_idx = 0;
  int          rx_len = 0;
  logic [15:0] got [512];
  int          got_n = 0;
  int          wr_low = 0;

  always #5 clk = ~clk;

  ft600_mode245 #(
    .RX_BUF_WIDTH (3),
    .TX_BUF_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_en    (tx_en),
    .tx_in    (tx_in),
    .tx_full  (tx_full),
    .rx_en    (rx_en),
    .rx_out   (rx_out),
    .rx_empty (rx_empty),
    .ft_data  (ft_data),
    .ft_be    (ft_be),
    .ft_txe   (ft_txe),
    .ft_rxf   (ft_rxf),
    .ft_oe    (ft_oe),
    .ft_rd    (ft_rd),
    .ft_wr    (ft_wr)
  );

  assign ft_rxf  = (host_idx < rx_len) ? 1'b0 : 1'b1;
  assign ft_data = (ft_oe == 1'b0) ? host_src[host_idx % 64] : 'z;

  always @(posedge clk) begin
    if (ft_rd == 1'b0 && ft_rxf == 1'b0) host_idx <= host_idx + 1;
    if (ft_wr == 1'b0 && ft_txe == 1'b0) begin
      got[got_n % 512] <= ft_data;
      got_n <= got_n + 1;
    end
    if (ft_wr == 1'b0) wr_low <= wr_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int g0, w0, n;
    logic [15:0] rcv [32];
    logic was_avail;

    for (int i = 0; i < 64; i++) host_src[i] = 16'hA000 + 16'(i);
    host_src[0] = 16'hFEDC;
    host_src[1] = 16'hBA98;

    // Reset and idle
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("rst_oe", 32'(ft_oe), 32'd1);
    check("rst_rd", 32'(ft_rd), 32'd1);
    check("rst_wr", 32'(ft_wr), 32'd1);
    check("rst_bus_released", 32'(dut.bus_drive), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_out", 32'(rx_out), 32'h0);

    // Plain three-word TX burst
    tx_en = 1'b1; tx_in = 16'h0001; step();
    tx_in = 16'h0203; step();
    tx_in = 16'h0405; step();
    tx_en = 1'b0;
    check("tx_idle_no_txe", 32'(ft_wr), 32'd1);
    g0 = got_n; w0 = wr_low;
    ft_txe = 1'b0;
    step();
    check("tx_w0_wr", 32'(ft_wr), 32'd0);
    check("tx_w0_data", 32'(ft_data), 32'h0001);
    check("tx_be", 32'(ft_be), 32'h3);
    step();
    check("tx_w1_data", 32'(ft_data), 32'h0203);
    step();
    check("tx_w2_data", 32'(ft_data), 32'h0405);
    step();
    check("tx_done_wr", 32'(ft_wr), 32'd1);
    check("tx_wr_low_cycles", 32'(wr_low - w0), 32'd3);
    check("tx_got_n", 32'(got_n - g0), 32'd3);
    check("tx_got0", 32'(got[g0]), 32'h0001);
    check("tx_got1", 32'(got[g0 + 1]), 32'h0203);
    check("tx_got2", 32'(got[g0 + 2]), 32'h0405);
    ft_txe = 1'b1;
    step();

    // TX burst with a one-cycle txe stall after the first word
    tx_en = 1'b1; tx_in = 16'h0001; step();
    tx_in = 16'h0203; step();
    tx_in = 16'h0405; step();
    tx_en = 1'b0;
    g0 = got_n;
    ft_txe = 1'b0;
    step();
    check("stall_w0_data", 32'(ft_data), 32'h0001);
    step();
    check("stall_w1_data", 32'(ft_data), 32'h0203);
    ft_txe = 1'b1;
    step();
    check("stall_wr_high", 32'(ft_wr), 32'd1);
    check("stall_got_n1", 32'(got_n - g0), 32'd1);
    ft_txe = 1'b0;
    step();
    check("stall_resend_data", 32'(ft_data), 32'h0203);
    step(); step(); step();
    ft_txe = 1'b1;
    check("stall_got_n3", 32'(got_n - g0), 32'd3);
    check("stall_got0", 32'(got[g0]), 32'h0001);
    check("stall_got1", 32'(got[g0 + 1]), 32'h0203);
    check("stall_got2", 32'(got[g0 + 2]), 32'h0405);

    // Two-word RX burst
    rx_len = 2;
    step();
    check("rx_oe_first_oe", 32'(ft_oe), 32'd0);
    check("rx_oe_first_rd", 32'(ft_rd), 32'd1);
    step();
    check("rx_read_oe", 32'(ft_oe), 32'd0);
    check("rx_read_rd", 32'(ft_rd), 32'd0);
    step(); step(); step();
    check("rx_end_oe", 32'(ft_oe), 32'd1);
    check("rx_end_rd", 32'(ft_rd), 32'd1);
    step();
    check("rx_not_empty", 32'(rx_empty), 32'd0);
    rx_en = 1'b1;
    step();
    check("rx_pop0", 32'(rx_out), 32'hFEDC);
    check("rx_after_pop0_empty", 32'(rx_empty), 32'd0);
    step();
    check("rx_pop1", 32'(rx_out), 32'hBA98);
    check("rx_drained_empty", 32'(rx_empty), 32'd1);
    step();
    check("rx_pop_empty_hold", 32'(rx_out), 32'hBA98);
    rx_en = 1'b0;
    step();
    check("rx_idle_hold", 32'(rx_out), 32'hBA98);

    // Eight-word RX FIFO with 20 pending host words: throttle, drain, resume
    rx_len = 22;
    for (int i = 0; i < 40; i++) step();
    check("thr_host_idx", 32'(host_idx), 32'd8);
    check("thr_rd_high", 32'(ft_rd), 32'd1);
    check("thr_oe_high", 32'(ft_oe), 32'd1);
    n = 0;
    for (int i = 0; i < 400 && n < 20; i++) begin
      rx_en = 1'b1;
      was_avail = !rx_empty;
      step();
      if (was_avail) begin
        rcv[n] = rx_out;
        n++;
      end
    end
    rx_en = 1'b0;
    check("thr_words_rcvd", 32'(n), 32'd20);
    check("thr_host_done", 32'(host_idx), 32'd22);
    for (int k = 0; k < 20; k++)
      check($sformatf("thr_word%0d", k), 32'(rcv[k]), 32'(16'hA000 + 16'(k + 2)));
    check("thr_rx_empty", 32'(rx_empty), 32'd1);

    // 257 pushes with no host; the last one is dropped
    g0 = got_n;
    for (int i = 0; i < 256; i++) begin
      tx_en = 1'b1;
      tx_in = 16'h1000 + 16'(i);
      step();
      if (i == 254) check("full_not_yet", 32'(tx_full), 32'd0);
    end
    check("full_at_256", 32'(tx_full), 32'd1);
    tx_in = 16'hDEAD;
    step();
    tx_en = 1'b0;
    check("full_after_drop", 32'(tx_full), 32'd1);
    ft_txe = 1'b0;
    for (int i = 0; i < 300; i++) step();
    ft_txe = 1'b1;
    check("full_drain_n", 32'(got_n - g0), 32'd256);
    check("full_drain_first", 32'(got[g0 % 512]), 32'h1000);
    check("full_drain_last", 32'(got[(g0 + 255) % 512]), 32'h10FF);
    check("full_cleared", 32'(tx_full), 32'd0);

    // Reset asserted in the middle of an RX burst
    rx_len = 32;
    for (int i = 0; i < 20 && ft_rd != 1'b0; i++) step();
    check("mid_rx_rd_low", 32'(ft_rd), 32'd0);
    step();
    check("mid_rx_not_empty", 32'(rx_empty), 32'd0);
    rst_n = 1'b0;
    #1;
    check("arst_oe", 32'(ft_oe), 32'd1);
    check("arst_rd", 32'(ft_rd), 32'd1);
    check("arst_wr", 32'(ft_wr), 32'd1);
    check("arst_bus_released", 32'(dut.bus_drive), 32'd0);
    check("arst_rx_empty", 32'(rx_empty), 32'd1);
    check("arst_tx_full", 32'(tx_full), 32'd0);
    check("arst_rx_out", 32'(rx_out), 32'h0);
    rx_len = host_idx;
    step();
    rst_n = 1'b1;
    step(); step();
    check("post_rst_rx_empty", 32'(rx_empty), 32'd1);
    check("post_rst_oe", 32'(ft_oe), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
